// File: rtl/charmap_scroll.sv
// charmap_scroll: scrolled character-map layer, 3-stage pixel pipeline.
// Ports: raster in (hcnt/vcnt/blank), scroll shadow write, RAM/ROM fetch, rgba out.
//   clk, reset_n          clock, async active-low reset
//   hcnt, vcnt            raster position; hblank, vblank blanking flags
//   scroll_x/y_in, we     shadow scroll write; bg_transparent bg opacity
//   chram_addr            {row, col} tilemap/colour RAM address
//   chmap/fgcol/bgcol     RAM data, 1 clock after chram_addr
//   chrom_addr            {code, pixel row} glyph ROM address
//   chrom_data_in         glyph row, 1 clock after chrom_addr, MSB leftmost
//   r, g, b, a            pixel colour and opacity
module charmap_scroll #(
  parameter int CHAR_W_LOG2  = 3,
  parameter int CHAR_H_LOG2  = 3,
  parameter int COLS_LOG2    = 6,
  parameter int ROWS_LOG2    = 6,
  parameter int BLINK_EN     = 1,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [8:0]                     hcnt,
  input  logic [8:0]                     vcnt,
  input  logic                           hblank,
  input  logic                           vblank,
  input  logic [8:0]                     scroll_x_in,
  input  logic [8:0]                     scroll_y_in,
  input  logic                           scroll_we,
  input  logic                           bg_transparent,
  output logic [ROWS_LOG2+COLS_LOG2-1:0] chram_addr,
  input  logic [7:0]                     chmap_data_in,
  input  logic [7:0]                     fgcol_data_in,
  input  logic [7:0]                     bgcol_data_in,
  output logic [8+CHAR_H_LOG2-1:0]       chrom_addr,
  input  logic [(1<<CHAR_W_LOG2)-1:0]    chrom_data_in,
  output logic [2:0]                     r,
  output logic [2:0]                     g,
  output logic [1:0]                     b,
  output logic                           a
);

  localparam int SXW = COLS_LOG2 + CHAR_W_LOG2;
  localparam int SYW = ROWS_LOG2 + CHAR_H_LOG2;
  localparam int AW  = ROWS_LOG2 + COLS_LOG2;
  localparam int CW  = 8 + CHAR_H_LOG2;
  localparam logic [7:0] BLAST = 8'(BLINK_FRAMES - 1);

  logic [8:0] shx_q, shy_q;
  logic [8:0] scx_q, scy_q;
  logic       vb_q;
  logic [7:0] bcnt_q;
  logic       boff_q;

  logic [AW-1:0]          chram_addr_q;
  logic [CHAR_W_LOG2-1:0] px1_q;
  logic [CHAR_H_LOG2-1:0] py1_q;
  logic                   blank1_q;

  logic [CW-1:0]          chrom_addr_q;
  logic [CHAR_W_LOG2-1:0] px2_q;
  logic [7:0]             fg2_q, bg2_q;
  logic                   blink2_q;
  logic                   blank2_q;

  logic [7:0] col_q, col_d;
  logic       a_q, a_d;

  logic [SXW-1:0] sx;
  logic [SYW-1:0] sy;
  logic           vrise;
  logic [7:0]     code;
  logic           blink_bit;
  logic           pix;
  logic           fg_on;

  assign sx    = SXW'(hcnt) + SXW'(scx_q);
  assign sy    = SYW'(vcnt) + SYW'(scy_q);
  assign vrise = vblank & ~vb_q;

  always_comb begin
    code      = chmap_data_in;
    blink_bit = 1'b0;
    if (BLINK_EN != 0) begin
      code[7]   = 1'b0;
      blink_bit = chmap_data_in[7];
    end
  end

  // Cell width is a power of two, so CHAR_W-1-col is just ~col.
  assign pix   = chrom_data_in[~px2_q];
  assign fg_on = pix & ~(blink2_q & boff_q);

  always_comb begin
    col_d = 8'h00;
    a_d   = 1'b0;
    if (!blank2_q) begin
      if (fg_on) begin
        col_d = fg2_q;
        a_d   = 1'b1;
      end else if (!bg_transparent) begin
        col_d = bg2_q;
        a_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shx_q  <= '0;
      shy_q  <= '0;
      scx_q  <= '0;
      scy_q  <= '0;
      vb_q   <= 1'b0;
      bcnt_q <= '0;
      boff_q <= 1'b0;
    end else begin
      vb_q <= vblank;
      if (scroll_we) begin
        shx_q <= scroll_x_in;
        shy_q <= scroll_y_in;
      end
      if (vrise) begin
        // A same-cycle shadow write bypasses straight into the actives.
        scx_q <= scroll_we ? scroll_x_in : shx_q;
        scy_q <= scroll_we ? scroll_y_in : shy_q;
        if (bcnt_q >= BLAST) begin
          bcnt_q <= '0;
          boff_q <= ~boff_q;
        end else begin
          bcnt_q <= bcnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chram_addr_q <= '0;
      px1_q        <= '0;
      py1_q        <= '0;
      blank1_q     <= 1'b0;
      chrom_addr_q <= '0;
      px2_q        <= '0;
      fg2_q        <= '0;
      bg2_q        <= '0;
      blink2_q     <= 1'b0;
      blank2_q     <= 1'b0;
      col_q        <= '0;
      a_q          <= 1'b0;
    end else begin
      chram_addr_q <= {sy[SYW-1:CHAR_H_LOG2], sx[SXW-1:CHAR_W_LOG2]};
      px1_q        <= sx[CHAR_W_LOG2-1:0];
      py1_q        <= sy[CHAR_H_LOG2-1:0];
      blank1_q     <= hblank | vblank;
      chrom_addr_q <= {code, py1_q};
      px2_q        <= px1_q;
      fg2_q        <= fgcol_data_in;
      bg2_q        <= bgcol_data_in;
      blink2_q     <= blink_bit;
      blank2_q     <= blank1_q;
      col_q        <= col_d;
      a_q          <= a_d;
    end
  end

  assign chram_addr = chram_addr_q;
  assign chrom_addr = chrom_addr_q;
  assign r          = col_q[2:0];
  assign g          = col_q[5:3];
  assign b          = col_q[7:6];
  assign a          = a_q;

endmodule

// File: tb/tb_charmap_scroll.sv
// tb_charmap_scroll: directed vectors for charmap_scroll.
// RAM/ROM data are held as bench variables and fed straight to the DUT.
module tb_charmap_scroll;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [8:0]  hcnt, vcnt;
  logic        hblank, vblank;
  logic [8:0]  scroll_x_in, scroll_y_in;
  logic        scroll_we;
  logic        bg_transparent;
  logic [11:0] chram_addr;
  logic [7:0]  chmap_data_in, fgcol_data_in, bgcol_data_in;
  logic [10:0] chrom_addr;
  logic [7:0]  chrom_data_in;
  logic [2:0]  r, g;
  logic [1:0]  b;
  logic        a;
  logic [8:0]  rgba;

  int checks   = 0;
  int failures = 0;

  assign rgba = {a, b, g, r};

  always #5 clk = ~clk;

  charmap_scroll #(
    .BLINK_FRAMES(2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .hcnt          (hcnt),
    .vcnt          (vcnt),
    .hblank        (hblank),
    .vblank        (vblank),
    .scroll_x_in   (scroll_x_in),
    .scroll_y_in   (scroll_y_in),
    .scroll_we     (scroll_we),
    .bg_transparent(bg_transparent),
    .chram_addr    (chram_addr),
    .chmap_data_in (chmap_data_in),
    .fgcol_data_in (fgcol_data_in),
    .bgcol_data_in (bgcol_data_in),
    .chrom_addr    (chrom_addr),
    .chrom_data_in (chrom_data_in),
    .r             (r),
    .g             (g),
    .b             (b),
    .a             (a)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    hcnt           = '0;
    vcnt           = '0;
    hblank         = 1'b0;
    vblank         = 1'b0;
    scroll_x_in    = '0;
    scroll_y_in    = '0;
    scroll_we      = 1'b0;
    bg_transparent = 1'b0;
    chmap_data_in  = '0;
    fgcol_data_in  = '0;
    bgcol_data_in  = '0;
    chrom_data_in  = '0;
    #3;
    chk("rst_chram", 32'(chram_addr), 32'h0);
    chk("rst_chrom", 32'(chrom_addr), 32'h0);
    chk("rst_rgba", 32'(rgba), 32'h0);
    tick(2);
    reset_n = 1'b1;

    hcnt          = 9'd17;
    vcnt          = 9'd9;
    chmap_data_in = 8'h41;
    fgcol_data_in = 8'hFF;
    bgcol_data_in = 8'hE3;
    chrom_data_in = 8'h40;
    tick();
    chk("s1_chram", 32'(chram_addr), 32'h042);
    tick();
    chk("s2_chrom", 32'(chrom_addr), 32'h209);
    tick();
    chk("s3_fg", 32'(rgba), 32'h1FF);

    chrom_data_in = 8'hBF;
    tick(3);
    chk("bg_opaque", 32'(rgba), 32'h1E3);
    bg_transparent = 1'b1;
    tick();
    chk("bg_transp", 32'(rgba), 32'h000);
    bg_transparent = 1'b0;
    tick();
    chk("bg_back", 32'(rgba), 32'h1E3);
    chrom_data_in = 8'h40;
    hblank        = 1'b1;
    tick(2);
    chk("blank_lat", 32'(rgba), 32'h1FF);
    tick();
    chk("hblank", 32'(rgba), 32'h000);
    hblank = 1'b0;

    scroll_x_in = 9'd8;
    scroll_we   = 1'b1;
    tick();
    scroll_we   = 1'b0;
    scroll_x_in = 9'd0;
    tick();
    chk("shadow_hold", 32'(chram_addr), 32'h042);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    hcnt   = 9'd0;
    tick();
    chk("scroll_x8", 32'(chram_addr), 32'h041);
    hcnt = 9'd504;
    tick();
    chk("scroll_wrap", 32'(chram_addr), 32'h040);

    vblank      = 1'b1;
    scroll_we   = 1'b1;
    scroll_x_in = 9'd8;
    scroll_y_in = 9'd16;
    tick();
    vblank      = 1'b0;
    scroll_we   = 1'b0;
    scroll_x_in = 9'd0;
    scroll_y_in = 9'd0;
    hcnt        = 9'd0;
    vcnt        = 9'd0;
    tick();
    chk("we_at_rise", 32'(chram_addr), 32'h081);
    chrom_data_in = 8'hFF;
    tick(3);
    chk("pre_reset", 32'(rgba), 32'h1FF);

    reset_n = 1'b0;
    #2;
    chk("async_chram", 32'(chram_addr), 32'h0);
    chk("async_chrom", 32'(chrom_addr), 32'h0);
    chk("async_rgba", 32'(rgba), 32'h0);
    tick();
    reset_n       = 1'b1;
    hcnt          = 9'd17;
    vcnt          = 9'd9;
    chmap_data_in = 8'h81;
    fgcol_data_in = 8'hFF;
    bgcol_data_in = 8'h00;
    chrom_data_in = 8'hFF;
    tick();
    chk("post_rst_scroll", 32'(chram_addr), 32'h042);
    tick();
    chk("blink_code", 32'(chrom_addr), 32'h009);
    tick();
    chk("frame0", 32'(rgba), 32'h1FF);

    for (int f = 1; f <= 5; f++) begin
      vblank = 1'b1;
      tick();
      vblank = 1'b0;
      tick(3);
      chk($sformatf("frame%0d", f), 32'(rgba),
          (f == 2 || f == 3) ? 32'h100 : 32'h1FF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
